writeback_regfile: RTL and testbench

Write-back stage and architectural register file for the SEQ Y86-64 processor. Each accepted instruction's valE and valM are written into fifteen 64-bit registers, at destinations derived from icode, cnd, rA and rB. The block owns the register state that the decode stage reads, provides two combinational read ports for decode, and tracks processor status (running, halted, error). It sits at the tail of the SEQ datapath and closes the loop back to decode.

---
 rtl/writeback_regfile.sv | 189 ++++++++++++++++++
 tb/tb_writeback_regfile.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_regfile.sv
// -----------------------------------------------------------------------------
// writeback_regfile
//   Write-back stage and architectural register file of the SEQ Y86-64 core.
//   Retired instructions write valE/valM into fifteen 64-bit registers at
//   destinations decoded from icode/cnd/rA/rB. The block also provides two
//   combinational read ports for decode and tracks run/halt/error status.
//
//   Optional feature: define WB_BYPASS_EN to forward same-cycle write data
//   onto rdA/rdB.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   wb_valid/wb_ready  write-back handshake (ready only while running)
//   icode, cnd         instruction code and cmovxx condition
//   rA, rB             register specifiers (4'hF = none)
//   valE, valM         execute / memory results
//   srcA/srcB, rdA/rdB read-port addresses and data (0 for address 4'hF)
//   reg_mem0..14       live register contents
//   halted, error      status flags
//   wb_count           number of accepted write-backs (wraps)
// -----------------------------------------------------------------------------
module writeback_regfile #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wb_valid,
   output logic             wb_ready,
   input  logic [3:0]       icode,
   input  logic             cnd,
   input  logic [3:0]       rA,
   input  logic [3:0]       rB,
   input  logic [63:0]      valE,
   input  logic [63:0]      valM,
   input  logic [3:0]       srcA,
   input  logic [3:0]       srcB,
   output logic [63:0]      rdA,
   output logic [63:0]      rdB,
   output logic [63:0]      reg_mem0,
   output logic [63:0]      reg_mem1,
   output logic [63:0]      reg_mem2,
   output logic [63:0]      reg_mem3,
   output logic [63:0]      reg_mem4,
   output logic [63:0]      reg_mem5,
   output logic [63:0]      reg_mem6,
   output logic [63:0]      reg_mem7,
   output logic [63:0]      reg_mem8,
   output logic [63:0]      reg_mem9,
   output logic [63:0]      reg_mem10,
   output logic [63:0]      reg_mem11,
   output logic [63:0]      reg_mem12,
   output logic [63:0]      reg_mem13,
   output logic [63:0]      reg_mem14,
   output logic             halted,
   output logic             error,
   output logic [CNT_W-1:0] wb_count
);

   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] RSP   = 4'h4;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HALT = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   state_t           state_q;
   logic             ready_q;
   logic             halted_q;
   logic             error_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [63:0]      regs_q [0:14];

   logic       accept;
   logic       retire_ok;
   logic [3:0] dstE;
   logic [3:0] dstM;
   logic [3:0] dstE_wr;
   logic [3:0] dstM_wr;

   assign accept    = wb_valid && ready_q;
   // halt (0) and invalid codes (>B) retire without touching registers
   assign retire_ok = accept && (icode != 4'h0) && (icode <= 4'hB);
   assign count_d   = count_q + 1'b1;

   always_comb begin
      dstE = RNONE;
      dstM = RNONE;
      case (icode)
         4'h2:                   dstE = cnd ? rB : RNONE;
         4'h3, 4'h6:             dstE = rB;
         4'h8, 4'h9, 4'hA, 4'hB: dstE = RSP;
         default:                dstE = RNONE;
      endcase
      if (icode == 4'h5 || icode == 4'hB)
         dstM = rA;
   end

   assign dstE_wr = retire_ok ? dstE : RNONE;
   assign dstM_wr = retire_ok ? dstM : RNONE;

   // Status FSM with registered outputs; count advances on every accept,
   // including the halt/invalid instruction that ends the run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RUN;
         ready_q  <= 1'b1;
         halted_q <= 1'b0;
         error_q  <= 1'b0;
         count_q  <= '0;
      end else begin
         if (accept)
            count_q <= count_d;
         case (state_q)
            ST_RUN: begin
               if (accept && icode == 4'h0) begin
                  state_q  <= ST_HALT;
                  ready_q  <= 1'b0;
                  halted_q <= 1'b1;
               end else if (accept && icode > 4'hB) begin
                  state_q <= ST_ERR;
                  ready_q <= 1'b0;
                  error_q <= 1'b1;
               end
            end
            ST_HALT, ST_ERR: ;
            default: begin
               state_q <= ST_ERR;
               ready_q <= 1'b0;
               error_q <= 1'b1;
            end
         endcase
      end
   end

   // Register file. The valM write is issued last so it wins when both
   // ports target the same register (popq %rsp).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 15; i++)
            regs_q[i] <= 64'(i);
      end else begin
         if (dstE_wr != RNONE)
            regs_q[dstE_wr] <= valE;
         if (dstM_wr != RNONE)
            regs_q[dstM_wr] <= valM;
      end
   end

   always_comb begin
      rdA = (srcA == RNONE) ? 64'd0 : regs_q[srcA];
      rdB = (srcB == RNONE) ? 64'd0 : regs_q[srcB];
`ifdef WB_BYPASS_EN
      // forward incoming data; dstM has priority over dstE
      if (srcA != RNONE) begin
         if (srcA == dstM_wr)      rdA = valM;
         else if (srcA == dstE_wr) rdA = valE;
      end
      if (srcB != RNONE) begin
         if (srcB == dstM_wr)      rdB = valM;
         else if (srcB == dstE_wr) rdB = valE;
      end
`endif
   end

   assign wb_ready  = ready_q;
   assign halted    = halted_q;
   assign error     = error_q;
   assign wb_count  = count_q;

   assign reg_mem0  = regs_q[0];
   assign reg_mem1  = regs_q[1];
   assign reg_mem2  = regs_q[2];
   assign reg_mem3  = regs_q[3];
   assign reg_mem4  = regs_q[4];
   assign reg_mem5  = regs_q[5];
   assign reg_mem6  = regs_q[6];
   assign reg_mem7  = regs_q[7];
   assign reg_mem8  = regs_q[8];
   assign reg_mem9  = regs_q[9];
   assign reg_mem10 = regs_q[10];
   assign reg_mem11 = regs_q[11];
   assign reg_mem12 = regs_q[12];
   assign reg_mem13 = regs_q[13];
   assign reg_mem14 = regs_q[14];

endmodule

// File: tb/tb_writeback_regfile.sv
// -----------------------------------------------------------------------------
// tb_writeback_regfile
//   Directed bench for writeback_regfile: a table of retire vectors applied
//   back-to-back from reset, followed by hand-written sequences for same-cycle
//   reads, halt, invalid instruction and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_writeback_regfile;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        wb_valid = 1'b0;
   logic        wb_ready;
   logic [3:0]  icode = 4'h1;
   logic        cnd = 1'b0;
   logic [3:0]  rA = 4'hF;
   logic [3:0]  rB = 4'hF;
   logic [63:0] valE = '0;
   logic [63:0] valM = '0;
   logic [3:0]  srcA = 4'hF;
   logic [3:0]  srcB = 4'hF;
   logic [63:0] rdA, rdB;
   logic [63:0] mem [0:15];
   logic        halted, error;
   logic [15:0] wb_count;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign mem[15] = 64'd0;

   writeback_regfile #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
      .icode(icode), .cnd(cnd), .rA(rA), .rB(rB), .valE(valE), .valM(valM),
      .srcA(srcA), .srcB(srcB), .rdA(rdA), .rdB(rdB),
      .reg_mem0(mem[0]), .reg_mem1(mem[1]), .reg_mem2(mem[2]), .reg_mem3(mem[3]),
      .reg_mem4(mem[4]), .reg_mem5(mem[5]), .reg_mem6(mem[6]), .reg_mem7(mem[7]),
      .reg_mem8(mem[8]), .reg_mem9(mem[9]), .reg_mem10(mem[10]), .reg_mem11(mem[11]),
      .reg_mem12(mem[12]), .reg_mem13(mem[13]), .reg_mem14(mem[14]),
      .halted(halted), .error(error), .wb_count(wb_count)
   );

   typedef struct {
      logic [3:0]  icode;
      logic        cnd;
      logic [3:0]  rA;
      logic [3:0]  rB;
      logic [63:0] valE;
      logic [63:0] valM;
      logic [3:0]  i1;
      logic [63:0] v1;
      logic [3:0]  i2;
      logic [63:0] v2;
      logic [15:0] cnt;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] ic, input logic c, input logic [3:0] a,
                        input logic [3:0] b, input logic [63:0] e, input logic [63:0] m);
      icode = ic; cnd = c; rA = a; rB = b; valE = e; valM = m;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      //            icode cnd  rA    rB    valE                     valM         i1    v1                       i2    v2       cnt
      vecs[0]  = '{4'h6, 1'b0, 4'hF, 4'h3, 64'h55,                  64'h0,       4'h3, 64'h55,                  4'h4, 64'h4,   16'd1};
      vecs[1]  = '{4'h2, 1'b0, 4'h1, 4'h3, 64'h77,                  64'h0,       4'h3, 64'h55,                  4'h0, 64'h0,   16'd2};
      vecs[2]  = '{4'h2, 1'b1, 4'h1, 4'h7, 64'h77,                  64'h0,       4'h7, 64'h77,                  4'h3, 64'h55,  16'd3};
      vecs[3]  = '{4'hB, 1'b0, 4'h4, 4'hF, 64'h100,                 64'hBEEF,    4'h4, 64'hBEEF,                4'h1, 64'h1,   16'd4};
      vecs[4]  = '{4'hB, 1'b0, 4'h1, 4'hF, 64'h100,                 64'hBEEF,    4'h4, 64'h100,                 4'h1, 64'hBEEF,16'd5};
      vecs[5]  = '{4'h5, 1'b0, 4'h2, 4'h8, 64'hDEAD,                64'h1234,    4'h2, 64'h1234,                4'h8, 64'h8,   16'd6};
      vecs[6]  = '{4'h8, 1'b0, 4'hF, 4'hF, 64'h200,                 64'h0,       4'h4, 64'h200,                 4'h3, 64'h55,  16'd7};
      vecs[7]  = '{4'h3, 1'b0, 4'hF, 4'hE, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,       4'hE, 64'hFFFF_FFFF_FFFF_FFFF, 4'h4, 64'h200, 16'd8};
      vecs[8]  = '{4'h1, 1'b0, 4'h9, 4'h9, 64'h5,                   64'h6,       4'h9, 64'h9,                   4'h0, 64'h0,   16'd9};
      vecs[9]  = '{4'h4, 1'b0, 4'hA, 4'hB, 64'h5,                   64'h6,       4'hA, 64'hA,                   4'hB, 64'hB,   16'd10};
      vecs[10] = '{4'h6, 1'b0, 4'h0, 4'hF, 64'h1,                   64'h2,       4'h0, 64'h0,                   4'hF, 64'h0,   16'd11};
      vecs[11] = '{4'hA, 1'b0, 4'h5, 4'hF, 64'h300,                 64'h9,       4'h4, 64'h300,                 4'h5, 64'h5,   16'd12};

      // reset state
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      srcA = 4'h2; srcB = 4'hF;
      #1;
      chk("rst_mem7", mem[7], 64'd7);
      chk("rst_mem14", mem[14], 64'd14);
      chk("rst_rdA", rdA, 64'd2);
      chk("rst_rdB_none", rdB, 64'd0);
      chk("rst_count", 64'(wb_count), 64'd0);
      chk("rst_halted", 64'(halted), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      chk("rst_ready", 64'(wb_ready), 64'd1);

      // table-driven retire sequence
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         drive(vecs[k].icode, vecs[k].cnd, vecs[k].rA, vecs[k].rB, vecs[k].valE, vecs[k].valM);
         srcA = vecs[k].i1; srcB = vecs[k].i2;
         wb_valid = 1'b1;
         tick();
         wb_valid = 1'b0;
         chk($sformatf("v%0d_mem1", k), mem[vecs[k].i1], vecs[k].v1);
         chk($sformatf("v%0d_mem2", k), mem[vecs[k].i2], vecs[k].v2);
         chk($sformatf("v%0d_rdA", k), rdA, vecs[k].v1);
         chk($sformatf("v%0d_rdB", k), rdB, vecs[k].v2);
         chk($sformatf("v%0d_cnt", k), 64'(wb_count), 64'(vecs[k].cnt));
      end

      // same-cycle read of a register being written
      @(negedge clk);
      drive(4'h3, 1'b0, 4'hF, 4'h6, 64'hAA, 64'h0);
      srcA = 4'h6; srcB = 4'h6;
      wb_valid = 1'b1;
      #1;
`ifdef WB_BYPASS_EN
      chk("byp_rdA_same", rdA, 64'hAA);
`else
      chk("nobyp_rdA_same", rdA, 64'd6);
`endif
      chk("pre_edge_mem6", mem[6], 64'd6);
      tick();
      wb_valid = 1'b0;
      chk("post_edge_rdA", rdA, 64'hAA);
      chk("post_edge_cnt", 64'(wb_count), 64'd13);

      // halt, then further requests ignored
      @(negedge clk);
      drive(4'h0, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0);
      wb_valid = 1'b1;
      tick();
      chk("halt_flag", 64'(halted), 64'd1);
      chk("halt_ready", 64'(wb_ready), 64'd0);
      chk("halt_cnt", 64'(wb_count), 64'd14);
      @(negedge clk);
      drive(4'h3, 1'b0, 4'hF, 4'h5, 64'h9, 64'h0);
      repeat (2) tick();
      wb_valid = 1'b0;
      chk("halt_mem5", mem[5], 64'd5);
      chk("halt_cnt_frozen", 64'(wb_count), 64'd14);
      chk("halt_sticky", 64'(halted), 64'd1);

      // asynchronous reset leaves HALT
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_halted", 64'(halted), 64'd0);
      chk("arst_ready", 64'(wb_ready), 64'd1);
      chk("arst_cnt", 64'(wb_count), 64'd0);
      chk("arst_mem6", mem[6], 64'd6);
      @(negedge clk);
      rst_n = 1'b1;

      // invalid instruction
      @(negedge clk);
      drive(4'hC, 1'b1, 4'h2, 4'h3, 64'h99, 64'h98);
      wb_valid = 1'b1;
      tick();
      chk("err_flag", 64'(error), 64'd1);
      chk("err_halted", 64'(halted), 64'd0);
      chk("err_cnt", 64'(wb_count), 64'd1);
      chk("err_mem3", mem[3], 64'd3);
      chk("err_mem2", mem[2], 64'd2);
      @(negedge clk);
      drive(4'h6, 1'b0, 4'hF, 4'h3, 64'h44, 64'h0);
      tick();
      wb_valid = 1'b0;
      chk("err_nowrite", mem[3], 64'd3);
      chk("err_cnt_frozen", 64'(wb_count), 64'd1);
      do_reset();
      chk("err_cleared", 64'(error), 64'd0);

      // mid-cycle reset overrides a pending accept
      @(negedge clk);
      drive(4'h6, 1'b0, 4'hF, 4'h8, 64'h88, 64'h0);
      wb_valid = 1'b1;
      tick();
      chk("pre_mid_mem8", mem[8], 64'h88);
      @(negedge clk);
      drive(4'h6, 1'b0, 4'hF, 4'h3, 64'h42, 64'h0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_mem8", mem[8], 64'd8);
      chk("mid_cnt", 64'(wb_count), 64'd0);
      tick();
      chk("mid_mem3_held", mem[3], 64'd3);
      chk("mid_cnt_held", 64'(wb_count), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wb_valid = 1'b0;
      tick();
      chk("post_rel_cnt", 64'(wb_count), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
